inv_sqrt_vec: RTL and testbench

- Vectorised G.729 `Inv_sqrt` engine.
- Takes a base read address, a base write address and a length, then walks the scratch memory.
- For each 32-bit `L_x` it computes the bit-exact G.729 `Inv_sqrt(L_x)` and writes the 32-bit result back.
- Replaces per-call single-value sequencing by the top-level FSM with one start/done handshake per vector.
- Normalisation is internal, single-cycle and combinational. The table comes from constant memory or from an internal ROM.

---
 rtl/inv_sqrt_vec.sv | 166 ++++++++++++++++
 tb/tb_inv_sqrt_vec.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sqrt_vec.sv
// inv_sqrt_vec: vectorised G.729 Inv_sqrt engine walking scratch memory from L_xAddr to L_yAddr.
// Define INV_SQRT_ROM_EN to use an internal tabsqr ROM instead of constant-memory fetches.
module inv_sqrt_vec #(
   parameter int ADDR_W = 11,
   parameter int CADDR_W = 12,
   parameter int LEN_W = 6,
   parameter logic [CADDR_W-1:0] TAB_BASE = '0
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic [ADDR_W-1:0] L_xAddr,
   input  logic [ADDR_W-1:0] L_yAddr,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0] memIn,
   output logic [ADDR_W-1:0] memReadAddr,
   output logic [ADDR_W-1:0] memWriteAddr,
   output logic [31:0] memOut,
   output logic memWriteEn,
   output logic [CADDR_W-1:0] constantMemAddr,
   input  logic [31:0] constantMemIn,
   output logic busy,
   output logic done
);
   typedef enum logic [3:0] {IDLE, RD, LATCH, NORM, TAB0, TAB1, CALC, WR, DONE} stateT;
   stateT state;
   logic [ADDR_W-1:0] xBase, yBase;
   logic [LEN_W-1:0] lenReg, k, kNext;
   logic [31:0] x, xs, xsAdj, prod, msu, calcRes;
   logic [4:0] n, eComb, e;
   logic [5:0] iComb, i;
   logic [14:0] aComb, a;
   logic [15:0] tLo, tHi, tmp;
   logic [32:0] diff;

   always_comb begin
      n = '0;
      for (int b = 0; b < 31; b++) if (x[b]) n = 5'(30 - b);
   end

   assign xs = x << n;
   assign xsAdj = n[0] ? xs : xs >> 1;
   assign eComb = ((5'd30 - n) >> 1) + 5'd1;
   assign iComb = xsAdj[30:25] - 6'd16;
   assign aComb = xsAdj[24:10];
   assign kNext = k + LEN_W'(1);

`ifdef INV_SQRT_ROM_EN
   localparam logic [15:0] TABSQR [49] = '{
      16'd32767, 16'd31790, 16'd30894, 16'd30070, 16'd29309, 16'd28602, 16'd27945, 16'd27330, 16'd26755, 16'd26214,
      16'd25705, 16'd25225, 16'd24770, 16'd24339, 16'd23930, 16'd23541, 16'd23170, 16'd22817, 16'd22479, 16'd22155,
      16'd21845, 16'd21548, 16'd21263, 16'd20988, 16'd20724, 16'd20470, 16'd20225, 16'd19988, 16'd19760, 16'd19539,
      16'd19326, 16'd19119, 16'd18919, 16'd18725, 16'd18536, 16'd18354, 16'd18176, 16'd18004, 16'd17837, 16'd17674,
      16'd17515, 16'd17361, 16'd17211, 16'd17064, 16'd16921, 16'd16782, 16'd16646, 16'd16514, 16'd16384};
   assign tLo = TABSQR[i];
   assign tHi = TABSQR[i + 6'd1];
   assign constantMemAddr = '0;
`else
   logic [15:0] t0, t1;
   logic [CADDR_W-1:0] cAddrHold;
   assign tLo = t0;
   assign tHi = t1;
   // first table address leaves straight from NORM so the word arrives in TAB0
   assign constantMemAddr = (state == NORM) ? TAB_BASE + CADDR_W'(iComb) : cAddrHold;
`endif

   // a is only 15 bits wide, so the L_mult step can never saturate
   assign tmp = tLo - tHi;
   assign prod = ({{16{tmp[15]}}, tmp} * {17'd0, a}) << 1;
   assign diff = {tLo[15], tLo, 16'h0000} - {prod[31], prod};
   assign msu = (diff[32] != diff[31]) ? (diff[32] ? 32'h80000000 : 32'h7FFFFFFF) : diff[31:0];
   assign calcRes = $signed(msu) >>> e;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         memWriteEn <= 1'b0;
         memReadAddr <= '0;
         memWriteAddr <= '0;
         memOut <= '0;
         xBase <= '0;
         yBase <= '0;
         lenReg <= '0;
         k <= '0;
         x <= '0;
         e <= '0;
         i <= '0;
         a <= '0;
`ifndef INV_SQRT_ROM_EN
         t0 <= '0;
         t1 <= '0;
         cAddrHold <= '0;
`endif
      end else begin
         memWriteEn <= 1'b0;
         case (state)
            IDLE: if (start) begin
               xBase <= L_xAddr;
               yBase <= L_yAddr;
               lenReg <= len;
               k <= '0;
               busy <= 1'b1;
               memReadAddr <= (len == '0) ? memReadAddr : L_xAddr;
               state <= (len == '0) ? DONE : RD;
            end
            RD: state <= LATCH;
            LATCH: begin
               x <= memIn;
               if (memIn[31] || memIn == '0) begin
                  memOut <= 32'h3FFFFFFF;
                  memWriteAddr <= yBase + ADDR_W'(k);
                  memWriteEn <= 1'b1;
                  state <= WR;
               end else state <= NORM;
            end
            NORM: begin
               e <= eComb;
               i <= iComb;
               a <= aComb;
`ifdef INV_SQRT_ROM_EN
               state <= CALC;
`else
               cAddrHold <= TAB_BASE + CADDR_W'(iComb) + CADDR_W'(1);
               state <= TAB0;
`endif
            end
`ifndef INV_SQRT_ROM_EN
            TAB0: begin
               t0 <= constantMemIn[15:0];
               state <= TAB1;
            end
            TAB1: begin
               t1 <= constantMemIn[15:0];
               state <= CALC;
            end
`endif
            CALC: begin
               memOut <= calcRes;
               memWriteAddr <= yBase + ADDR_W'(k);
               memWriteEn <= 1'b1;
               state <= WR;
            end
            WR: begin
               k <= kNext;
               if (kNext == lenReg) begin
                  state <= DONE;
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  state <= RD;
                  memReadAddr <= xBase + ADDR_W'(kNext);
               end
            end
            // an empty vector enters with done low and spends one extra cycle here
            DONE: begin
               done <= !done;
               busy <= 1'b0;
               state <= done ? IDLE : DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_sqrt_vec.sv
// tb_inv_sqrt_vec: randomized and directed checks of inv_sqrt_vec against an arithmetic Inv_sqrt model.
module tb_inv_sqrt_vec;
`ifdef INV_SQRT_ROM_EN
   localparam int POS_LAT = 5, ABORT_CYC = 9;
`else
   localparam int POS_LAT = 7, ABORT_CYC = 12;
`endif
   localparam int TAB [49] = '{
      32767, 31790, 30894, 30070, 29309, 28602, 27945, 27330, 26755, 26214,
      25705, 25225, 24770, 24339, 23930, 23541, 23170, 22817, 22479, 22155,
      21845, 21548, 21263, 20988, 20724, 20470, 20225, 19988, 19760, 19539,
      19326, 19119, 18919, 18725, 18536, 18354, 18176, 18004, 17837, 17674,
      17515, 17361, 17211, 17064, 16921, 16782, 16646, 16514, 16384};

   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [10:0] L_xAddr = '0, L_yAddr = '0;
   logic [5:0] len = '0;
   logic [31:0] memIn = '0, constantMemIn = '0;
   logic [10:0] memReadAddr, memWriteAddr;
   logic [31:0] memOut;
   logic memWriteEn, busy, done;
   logic [11:0] constantMemAddr;

   logic [31:0] mem [2048];
   logic [15:0] cmem [4096];
   logic tbWe = 1'b0;
   logic [10:0] tbAddr = '0;
   logic [31:0] tbData = '0;
   logic [11:0] prevC = '0;
   int writes = 0, dones = 0, cMoves = 0;
   int compared = 0, mismatched = 0;

   inv_sqrt_vec dut (
      .clk(clk), .reset(reset), .start(start), .L_xAddr(L_xAddr), .L_yAddr(L_yAddr), .len(len),
      .memIn(memIn), .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
      .memWriteEn(memWriteEn), .constantMemAddr(constantMemAddr), .constantMemIn(constantMemIn),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (memWriteEn) begin
         mem[memWriteAddr] <= memOut;
         writes <= writes + 1;
      end else if (tbWe) mem[tbAddr] <= tbData;
      memIn <= mem[memReadAddr];
      constantMemIn <= {16'hA5C3, cmem[constantMemAddr]};
      if (done) dones <= dones + 1;
      if (constantMemAddr !== prevC) cMoves <= cMoves + 1;
      prevC <= constantMemAddr;
   end

   function automatic logic [31:0] refInv(input logic [31:0] lx);
      longint v, y;
      int nz, ex, idx, frac;
      if ($signed(lx) <= 0) return 32'h3FFFFFFF;
      v = longint'(lx);
      nz = 0;
      while (v < 64'd1073741824) begin
         v = v * 2;
         nz++;
      end
      ex = 30 - nz;
      if (ex % 2 == 0) v = v / 2;
      ex = ex / 2 + 1;
      idx = int'(v / 33554432) - 16;
      frac = int'((v / 1024) % 32768);
      y = longint'(TAB[idx]) * 65536 - 2 * longint'(TAB[idx] - TAB[idx + 1]) * longint'(frac);
      return 32'(y / (longint'(1) << ex));
   endfunction

   task automatic poke(input logic [10:0] ad, input logic [31:0] d);
      @(negedge clk);
      tbWe = 1'b1;
      tbAddr = ad;
      tbData = d;
      @(negedge clk);
      tbWe = 1'b0;
   endtask

   task automatic runVec(input logic [10:0] xa, input logic [10:0] ya, input int n, output int cyc);
      @(negedge clk);
      L_xAddr = xa;
      L_yAddr = ya;
      len = 6'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cyc);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b1;
      L_xAddr = 11'h123;
      len = 6'd5;
      repeat (3) @(negedge clk);
      start = 1'b0;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b need 0", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b need 0", done); end
      compared++; if (memWriteEn !== 1'b0) begin mismatched++; $display("FAIL rst_we: got %b need 0", memWriteEn); end
      compared++; if (memReadAddr !== 11'h0) begin mismatched++; $display("FAIL rst_raddr: got %h need 0", memReadAddr); end
      compared++; if (memWriteAddr !== 11'h0) begin mismatched++; $display("FAIL rst_waddr: got %h need 0", memWriteAddr); end
      compared++; if (memOut !== 32'h0) begin mismatched++; $display("FAIL rst_out: got %h need 0", memOut); end
      compared++; if (constantMemAddr !== 12'h0) begin mismatched++; $display("FAIL rst_caddr: got %h need 0", constantMemAddr); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL start_with_reset: busy=%b need 0", busy); end
   endtask

   task automatic test_single;
      logic [31:0] xv [5] = '{32'h40000000, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h80000000};
      logic [31:0] ev [5] = '{32'h00007FFF, 32'h00005A82, 32'h3FFF8000, 32'h3FFFFFFF, 32'h3FFFFFFF};
      int cyc, w0, c0;
      for (int j = 0; j < 5; j++) begin
         poke(11'h010, xv[j]);
         poke(11'h020, 32'hDEADBEEF);
         w0 = writes;
         c0 = cMoves;
         runVec(11'h010, 11'h020, 1, cyc);
         compared++; if (mem[11'h020] !== ev[j]) begin mismatched++; $display("FAIL single_res[%0d]: got %h need %h", j, mem[11'h020], ev[j]); end
         compared++; if (cyc !== ((j < 3) ? POS_LAT + 1 : 4)) begin mismatched++; $display("FAIL single_cyc[%0d]: got %0d need %0d", j, cyc, (j < 3) ? POS_LAT + 1 : 4); end
         compared++; if (writes - w0 !== 1) begin mismatched++; $display("FAIL single_writes[%0d]: got %0d need 1", j, writes - w0); end
         if (j >= 3) begin
            compared++; if (cMoves !== c0) begin mismatched++; $display("FAIL single_cmem_idle[%0d]: got %0d moves need 0", j, cMoves - c0); end
         end
      end
   endtask

   task automatic test_inplace_wrap;
      logic [31:0] xv [4] = '{32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h80000000};
      logic [31:0] ev [4] = '{32'h00005A82, 32'h3FFF8000, 32'h3FFFFFFF, 32'h3FFFFFFF};
      logic [10:0] ad;
      int cyc, w0, d0;
      for (int j = 0; j < 4; j++) poke(11'h7FE + 11'(j), xv[j]);
      poke(11'h7FD, 32'h0BADF00D);
      poke(11'h002, 32'h0BADF00D);
      w0 = writes;
      d0 = dones;
      runVec(11'h7FE, 11'h7FE, 4, cyc);
      repeat (3) @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         ad = 11'h7FE + 11'(j);
         compared++; if (mem[ad] !== ev[j]) begin mismatched++; $display("FAIL wrap_res[%h]: got %h need %h", ad, mem[ad], ev[j]); end
      end
      compared++; if (cyc !== 2 * POS_LAT + 7) begin mismatched++; $display("FAIL wrap_cyc: got %0d need %0d", cyc, 2 * POS_LAT + 7); end
      compared++; if (writes - w0 !== 4) begin mismatched++; $display("FAIL wrap_writes: got %0d need 4", writes - w0); end
      compared++; if (dones - d0 !== 1) begin mismatched++; $display("FAIL wrap_done_pulses: got %0d need 1", dones - d0); end
      compared++; if (mem[11'h7FD] !== 32'h0BADF00D || mem[11'h002] !== 32'h0BADF00D) begin mismatched++; $display("FAIL wrap_neighbours: got %h %h need 0badf00d", mem[11'h7FD], mem[11'h002]); end
   endtask

   task automatic test_len0;
      logic [10:0] r0;
      int cyc, w0;
      r0 = memReadAddr;
      w0 = writes;
      runVec(11'h300, 11'h310, 0, cyc);
      compared++; if (cyc !== 2) begin mismatched++; $display("FAIL len0_cyc: got %0d need 2", cyc); end
      compared++; if (writes !== w0) begin mismatched++; $display("FAIL len0_writes: got %0d need 0", writes - w0); end
      compared++; if (memReadAddr !== r0) begin mismatched++; $display("FAIL len0_raddr: got %h need %h", memReadAddr, r0); end
      @(negedge clk);
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL len0_pulse: done=%b need 0", done); end
   endtask

   task automatic test_back_to_back_start;
      logic [31:0] v [3];
      int cyc, w0, d0, expc;
      v[0] = (32'($urandom) & 32'h7FFFFFFF) | 32'h1;
      v[1] = 32'($urandom) | 32'h80000000;
      v[2] = (32'($urandom) >> 4) | 32'h1;
      expc = 2 * POS_LAT + 4;
      for (int j = 0; j < 3; j++) poke(11'h100 + 11'(j), v[j]);
      poke(11'h400, 32'h12345678);
      w0 = writes;
      d0 = dones;
      @(negedge clk);
      L_xAddr = 11'h100;
      L_yAddr = 11'h180;
      len = 6'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      repeat (2) begin
         @(negedge clk);
         cyc++;
      end
      L_xAddr = 11'h200;
      L_yAddr = 11'h400;
      len = 6'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      compared++; if (cyc !== expc) begin mismatched++; $display("FAIL busy_cyc: got %0d need %0d", cyc, expc); end
      repeat (3) @(negedge clk);
      compared++; if (writes - w0 !== 3) begin mismatched++; $display("FAIL busy_writes: got %0d need 3", writes - w0); end
      compared++; if (dones - d0 !== 1) begin mismatched++; $display("FAIL busy_done_pulses: got %0d need 1", dones - d0); end
      compared++; if (mem[11'h400] !== 32'h12345678) begin mismatched++; $display("FAIL busy_ignored: got %h need 12345678", mem[11'h400]); end
      for (int j = 0; j < 3; j++) begin
         compared++; if (mem[11'h180 + 11'(j)] !== refInv(v[j])) begin mismatched++; $display("FAIL busy_res[%0d]: got %h need %h", j, mem[11'h180 + 11'(j)], refInv(v[j])); end
      end
   endtask

   task automatic test_random;
      for (int t = 0; t < 24; t++) begin
         logic [31:0] v [8];
         logic [10:0] xa, ya;
         int n, cyc, expc, w0;
         n = $urandom_range(1, 8);
         xa = 11'($urandom);
         ya = ($urandom_range(0, 1) == 1) ? xa : xa ^ 11'h400;
         expc = 1;
         for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 3))
               0: v[j] = $urandom;
               1: v[j] = 32'($urandom) >> $urandom_range(0, 31);
               2: v[j] = ($urandom_range(0, 1) == 1) ? 32'h0 : (32'($urandom) | 32'h80000000);
               default: v[j] = 32'($urandom) >> 1;
            endcase
            expc += ($signed(v[j]) > 0) ? POS_LAT : 3;
            poke(xa + 11'(j), v[j]);
         end
         w0 = writes;
         runVec(xa, ya, n, cyc);
         compared++; if (cyc !== expc) begin mismatched++; $display("FAIL rand_cyc[%0d]: got %0d need %0d", t, cyc, expc); end
         compared++; if (writes - w0 !== n) begin mismatched++; $display("FAIL rand_writes[%0d]: got %0d need %0d", t, writes - w0, n); end
         for (int j = 0; j < n; j++) begin
            compared++; if (mem[ya + 11'(j)] !== refInv(v[j])) begin mismatched++; $display("FAIL rand_res[%0d.%0d] x=%h: got %h need %h", t, j, v[j], mem[ya + 11'(j)], refInv(v[j])); end
         end
      end
   endtask

   task automatic test_reset_abort;
      logic [31:0] v [3];
      int cyc, w0;
      for (int j = 0; j < 3; j++) begin
         v[j] = (32'($urandom) >> $urandom_range(0, 20)) & 32'h7FFFFFFF | 32'h1;
         poke(11'h500 + 11'(j), v[j]);
         poke(11'h540 + 11'(j), 32'hCAFEBABE);
      end
      w0 = writes;
      @(negedge clk);
      L_xAddr = 11'h500;
      L_yAddr = 11'h540;
      len = 6'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (ABORT_CYC - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      compared++; if ({busy, done, memWriteEn} !== 3'b000) begin mismatched++; $display("FAIL abort_ctrl: busy/done/we=%b need 000", {busy, done, memWriteEn}); end
      compared++; if (memReadAddr !== 11'h0 || memWriteAddr !== 11'h0) begin mismatched++; $display("FAIL abort_addr: raddr=%h waddr=%h need 0", memReadAddr, memWriteAddr); end
      compared++; if (memOut !== 32'h0 || constantMemAddr !== 12'h0) begin mismatched++; $display("FAIL abort_data: out=%h caddr=%h need 0", memOut, constantMemAddr); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      compared++; if (writes - w0 !== 1) begin mismatched++; $display("FAIL abort_writes: got %0d need 1", writes - w0); end
      compared++; if (mem[11'h540] !== refInv(v[0])) begin mismatched++; $display("FAIL abort_first: got %h need %h", mem[11'h540], refInv(v[0])); end
      compared++; if (mem[11'h541] !== 32'hCAFEBABE) begin mismatched++; $display("FAIL abort_second: got %h need cafebabe", mem[11'h541]); end
      runVec(11'h500, 11'h540, 3, cyc);
      compared++; if (cyc !== 3 * POS_LAT + 1) begin mismatched++; $display("FAIL rerun_cyc: got %0d need %0d", cyc, 3 * POS_LAT + 1); end
      for (int j = 0; j < 3; j++) begin
         compared++; if (mem[11'h540 + 11'(j)] !== refInv(v[j])) begin mismatched++; $display("FAIL rerun_res[%0d]: got %h need %h", j, mem[11'h540 + 11'(j)], refInv(v[j])); end
      end
   endtask

   initial begin
      for (int j = 0; j < 4096; j++) cmem[j] = (j < 49) ? 16'(TAB[j]) : 16'(j * 7);
      test_reset;
      test_single;
      test_inplace_wrap;
      test_len0;
      test_back_to_back_start;
      test_random;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
